// File: rtl/tdc_seq_pkg.sv
// Shared types and default widths for the TDC measurement sequencer.
// The stats record is sized with the default widths.
package tdc_seq_pkg;

    localparam int unsigned DEF_TIME_W = 37;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned DEF_TMO_W  = 24;
    localparam int unsigned DEF_SUM_W  = DEF_TIME_W + DEF_CNT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [DEF_SUM_W-1:0]  sum;
        logic [DEF_TIME_W-1:0] t_min;
        logic [DEF_TIME_W-1:0] t_max;
        logic [DEF_CNT_W-1:0]  hits;
        logic [DEF_CNT_W-1:0]  tmo;
        logic                  aborted;
    } tdc_stats_t;

endpackage

// File: rtl/tdc_stat_acc.sv
// Burst statistics accumulator: sum, min/max, hit and timeout counts, abort flag.
// Cleared on clr, updated on acc/tmo_inc/set_abort strobes from the sequencer FSM.
module tdc_stat_acc
    import tdc_seq_pkg::*;
#(
    parameter int unsigned TIME_W = DEF_TIME_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                    pll_clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    acc,
    input  logic                    tmo_inc,
    input  logic                    set_abort,
    input  logic [TIME_W-1:0]       tdc_time,
    output logic [TIME_W+CNT_W-1:0] res_sum,
    output logic [TIME_W-1:0]       res_min,
    output logic [TIME_W-1:0]       res_max,
    output logic [CNT_W-1:0]        res_hits,
    output logic [CNT_W-1:0]        res_tmo,
    output logic                    res_aborted
);

    localparam int unsigned SUM_W = TIME_W + CNT_W;

    logic [SUM_W-1:0]  sum_q;
    logic [TIME_W-1:0] min_q;
    logic [TIME_W-1:0] max_q;
    logic [CNT_W-1:0]  hits_q;
    logic [CNT_W-1:0]  tmo_q;
    logic              aborted_q;

    always_ff @(posedge pll_clk) begin
        if (rst || clr) begin
            sum_q     <= '0;
            min_q     <= '1;
            max_q     <= '0;
            hits_q    <= '0;
            tmo_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (acc) begin
                sum_q  <= sum_q + SUM_W'(tdc_time);
                hits_q <= hits_q + CNT_W'(1);
                if (tdc_time < min_q) min_q <= tdc_time;
                if (tdc_time > max_q) max_q <= tdc_time;
            end
            if (tmo_inc) tmo_q <= tmo_q + CNT_W'(1);
            if (set_abort) aborted_q <= 1'b1;
        end
    end

    // min tracks from all-ones; report 0 until a hit has been seen
    assign res_min     = (hits_q == '0) ? '0 : min_q;
    assign res_sum     = sum_q;
    assign res_max     = max_q;
    assign res_hits    = hits_q;
    assign res_tmo     = tmo_q;
    assign res_aborted = aborted_q;

endmodule

// File: rtl/tdc_meas_seq.sv
// TDC measurement sequencer: runs a burst of armed single-shot measurements with
// per-shot timeout and hands one statistics record to the readout over valid/ready.
module tdc_meas_seq
    import tdc_seq_pkg::*;
#(
    parameter int unsigned TIME_W = DEF_TIME_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned TMO_W  = DEF_TMO_W
) (
    input  logic                    pll_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        n_meas,
    input  logic [TMO_W-1:0]        timeout,
    input  logic                    abort,
    input  logic [TIME_W-1:0]       tdc_time,
    input  logic                    tdc_dval,
    output logic                    tdc_arm,
    output logic                    busy,
    output logic                    cfg_err,
    output logic [TIME_W+CNT_W-1:0] res_sum,
    output logic [TIME_W-1:0]       res_min,
    output logic [TIME_W-1:0]       res_max,
    output logic [CNT_W-1:0]        res_hits,
    output logic [CNT_W-1:0]        res_tmo,
    output logic                    res_aborted,
    output logic                    res_valid,
    input  logic                    res_ready
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] n_meas_q, n_meas_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_cfg_q, tmo_cfg_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             cfg_err_q, cfg_err_d;
    logic             clr, acc, tmo_inc, set_abort;

    always_ff @(posedge pll_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_meas_q  <= '0;
            idx_q     <= '0;
            tmo_cfg_q <= '0;
            tmo_cnt_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_meas_q  <= n_meas_d;
            idx_q     <= idx_d;
            tmo_cfg_q <= tmo_cfg_d;
            tmo_cnt_q <= tmo_cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_meas_d  = n_meas_q;
        idx_d     = idx_q;
        tmo_cfg_d = tmo_cfg_q;
        tmo_cnt_d = tmo_cnt_q;
        cfg_err_d = 1'b0;
        clr       = 1'b0;
        acc       = 1'b0;
        tmo_inc   = 1'b0;
        set_abort = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_meas == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        n_meas_d  = n_meas;
                        tmo_cfg_d = timeout;
                        tmo_cnt_d = timeout;
                        idx_d     = '0;
                        clr       = 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                // a result arriving on the expiry cycle still counts as a hit
                if (tdc_dval) begin
                    acc     = 1'b1;
                    state_d = GAP;
                end else if (tmo_cfg_q != '0 && tmo_cnt_q == TMO_W'(1)) begin
                    tmo_inc = 1'b1;
                    state_d = GAP;
                end
                if (abort) begin
                    set_abort = 1'b1;
                    state_d   = DONE;
                end
            end
            GAP: begin
                idx_d     = idx_q + CNT_W'(1);
                tmo_cnt_d = tmo_cfg_q;
                if (abort) begin
                    set_abort = 1'b1;
                    state_d   = DONE;
                end else if (idx_q + CNT_W'(1) == n_meas_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    tdc_stat_acc #(
        .TIME_W(TIME_W),
        .CNT_W (CNT_W)
    ) u_stat_acc (
        .pll_clk    (pll_clk),
        .rst        (rst),
        .clr        (clr),
        .acc        (acc),
        .tmo_inc    (tmo_inc),
        .set_abort  (set_abort),
        .tdc_time   (tdc_time),
        .res_sum    (res_sum),
        .res_min    (res_min),
        .res_max    (res_max),
        .res_hits   (res_hits),
        .res_tmo    (res_tmo),
        .res_aborted(res_aborted)
    );

    assign tdc_arm   = (state_q == WAIT);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_tdc_meas_seq.sv
// Directed bench for tdc_meas_seq: expected records are queued when a burst is
// launched and compared against the DUT when res_valid appears.
module tb_tdc_meas_seq;
    import tdc_seq_pkg::*;

    localparam int unsigned TIME_W = DEF_TIME_W;
    localparam int unsigned CNT_W  = DEF_CNT_W;
    localparam int unsigned TMO_W  = DEF_TMO_W;
    localparam int unsigned SUM_W  = DEF_SUM_W;

    logic              pll_clk;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  n_meas;
    logic [TMO_W-1:0]  timeout;
    logic              abort;
    logic [TIME_W-1:0] tdc_time;
    logic              tdc_dval;
    logic              tdc_arm;
    logic              busy;
    logic              cfg_err;
    logic [SUM_W-1:0]  res_sum;
    logic [TIME_W-1:0] res_min;
    logic [TIME_W-1:0] res_max;
    logic [CNT_W-1:0]  res_hits;
    logic [CNT_W-1:0]  res_tmo;
    logic              res_aborted;
    logic              res_valid;
    logic              res_ready;

    int total = 0;
    int bad   = 0;
    tdc_stats_t exp_q[$];

    tdc_meas_seq dut (
        .pll_clk    (pll_clk),
        .rst        (rst),
        .start      (start),
        .n_meas     (n_meas),
        .timeout    (timeout),
        .abort      (abort),
        .tdc_time   (tdc_time),
        .tdc_dval   (tdc_dval),
        .tdc_arm    (tdc_arm),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .res_sum    (res_sum),
        .res_min    (res_min),
        .res_max    (res_max),
        .res_hits   (res_hits),
        .res_tmo    (res_tmo),
        .res_aborted(res_aborted),
        .res_valid  (res_valid),
        .res_ready  (res_ready)
    );

    initial pll_clk = 1'b0;
    always #5 pll_clk = ~pll_clk;

    task automatic tick();
        @(posedge pll_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic tdc_stats_t mk(input logic [63:0] s, input logic [63:0] mn,
                                      input logic [63:0] mx, input int h, input int t,
                                      input logic ab);
        tdc_stats_t r;
        r.sum     = SUM_W'(s);
        r.t_min   = TIME_W'(mn);
        r.t_max   = TIME_W'(mx);
        r.hits    = CNT_W'(h);
        r.tmo     = CNT_W'(t);
        r.aborted = ab;
        return r;
    endfunction

    task automatic launch(input int n, input int tmo);
        n_meas  = CNT_W'(n);
        timeout = TMO_W'(tmo);
        start   = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic get_record(input string tag);
        tdc_stats_t e;
        int n = 0;
        while (res_valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_queued"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, 64'(res_sum), 64'(e.sum));
            chk({tag, "_min"}, 64'(res_min), 64'(e.t_min));
            chk({tag, "_max"}, 64'(res_max), 64'(e.t_max));
            chk({tag, "_hits"}, 64'(res_hits), 64'(e.hits));
            chk({tag, "_tmo"}, 64'(res_tmo), 64'(e.tmo));
            chk({tag, "_aborted"}, 64'(res_aborted), 64'(e.aborted));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_release_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_release_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic arm_run(output int n);
        n = 0;
        while (tdc_arm === 1'b1 && n < 50) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int        run;
        longint unsigned big;
        logic [TIME_W-1:0] tmax;

        rst = 1'b1; start = 1'b0; n_meas = '0; timeout = '0; abort = 1'b0;
        tdc_time = '0; tdc_dval = 1'b0; res_ready = 1'b0;
        tick();
        tick();
        chk("rst_arm", 64'(tdc_arm), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_sum", 64'(res_sum), 64'd0);
        chk("rst_min", 64'(res_min), 64'd0);
        rst = 1'b0;
        tick();

        // normal burst
        exp_q.push_back(mk(2100, 400, 1000, 3, 0, 1'b0));
        launch(3, 100);
        chk("norm_arm_t1", 64'(tdc_arm), 64'd1);
        chk("norm_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            repeat (9) tick();
            tdc_dval = 1'b1;
            tdc_time = (i == 0) ? TIME_W'(1000) : (i == 1) ? TIME_W'(400) : TIME_W'(700);
            tick();
            tdc_dval = 1'b0;
            chk("norm_gap_arm", 64'(tdc_arm), 64'd0);
            tick();
            if (i < 2) chk("norm_rearm", 64'(tdc_arm), 64'd1);
            else chk("norm_valid_t1", 64'(res_valid), 64'd1);
        end
        get_record("norm");

        // timeouts only
        exp_q.push_back(mk(0, 0, 0, 0, 2, 1'b0));
        launch(2, 5);
        arm_run(run);
        chk("tmo_wait1_len", 64'(run), 64'd5);
        tick();
        chk("tmo_rearm", 64'(tdc_arm), 64'd1);
        arm_run(run);
        chk("tmo_wait2_len", 64'(run), 64'd5);
        get_record("tmo");

        // dval on the expiry cycle
        exp_q.push_back(mk(110, 33, 77, 2, 0, 1'b0));
        launch(2, 4);
        repeat (3) tick();
        tdc_dval = 1'b1;
        tdc_time = TIME_W'(77);
        tick();
        tdc_dval = 1'b0;
        chk("coll_gap_arm", 64'(tdc_arm), 64'd0);
        chk("coll_tmo_cnt", 64'(res_tmo), 64'd0);
        tick();
        chk("coll_rearm", 64'(tdc_arm), 64'd1);
        tdc_dval = 1'b1;
        tdc_time = TIME_W'(33);
        tick();
        tdc_dval = 1'b0;
        tick();
        get_record("coll");

        // abort with a coincident hit, plus dval in GAP to be ignored
        exp_q.push_back(mk(110, 50, 60, 2, 0, 1'b1));
        launch(10, 0);
        repeat (2) tick();
        tdc_dval = 1'b1;
        tdc_time = TIME_W'(50);
        tick();
        tdc_time = TIME_W'(999);
        tick();
        tdc_dval = 1'b0;
        chk("abort_gap_dval_arm", 64'(tdc_arm), 64'd1);
        chk("abort_gap_dval_hits", 64'(res_hits), 64'd1);
        repeat (3) tick();
        tdc_dval = 1'b1;
        tdc_time = TIME_W'(60);
        abort = 1'b1;
        tick();
        tdc_dval = 1'b0;
        abort = 1'b0;
        chk("abort_valid", 64'(res_valid), 64'd1);
        chk("abort_flag", 64'(res_aborted), 64'd1);
        chk("abort_arm", 64'(tdc_arm), 64'd0);

        // back-pressure on the aborted record; start/abort/dval must be ignored
        for (int c = 0; c < 20; c++) begin
            start    = (c == 4 || c == 8);
            n_meas   = (c == 8) ? CNT_W'(0) : CNT_W'(5);
            abort    = (c == 12);
            tdc_dval = (c == 14);
            tick();
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_sum", 64'(res_sum), 64'd110);
            chk("bp_hits", 64'(res_hits), 64'd2);
            chk("bp_cfg_err", 64'(cfg_err), 64'd0);
        end
        start = 1'b0; abort = 1'b0; tdc_dval = 1'b0;
        get_record("bp");
        tick();
        chk("bp_idle_after", 64'(busy), 64'd0);

        // start with zero length
        launch(0, 10);
        chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
        chk("cfg_busy", 64'(busy), 64'd0);
        tick();
        chk("cfg_err_clear", 64'(cfg_err), 64'd0);

        // full-length burst at maximum time: sum must not wrap
        tmax = '1;
        big  = 0;
        for (int i = 0; i < 255; i++) big += 64'(tmax);
        exp_q.push_back(mk(big, 64'(tmax), 64'(tmax), 255, 0, 1'b0));
        launch(255, 0);
        for (int i = 0; i < 255; i++) begin
            tdc_dval = 1'b1;
            tdc_time = tmax;
            tick();
            tdc_dval = 1'b0;
            tick();
        end
        get_record("max");

        // reset during WAIT discards the burst
        launch(3, 0);
        tdc_dval = 1'b1;
        tdc_time = TIME_W'(500);
        tick();
        tdc_dval = 1'b0;
        tick();
        chk("rstw_in_wait", 64'(tdc_arm), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_arm", 64'(tdc_arm), 64'd0);
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_valid", 64'(res_valid), 64'd0);
        chk("rstw_sum", 64'(res_sum), 64'd0);
        chk("rstw_hits", 64'(res_hits), 64'd0);
        chk("rstw_max", 64'(res_max), 64'd0);
        tick();
        chk("rstw_stay_idle", 64'(busy), 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
